// File: rtl/carry_chain_addsub_pipe.sv
// Two-stage pipelined adder/subtractor with the carry chain split at WIDTH/2.
// Computes a + (b ^ {WIDTH{sub}}) + cin0, where cin0 comes from the C_INIT select.
// The low half and the mid-carry are registered in stage 1; the high half
// completes in stage 2, so each stage ripples through only half the chain.
module carry_chain_addsub_pipe #(
  parameter int         WIDTH  = 16,
  parameter logic [1:0] C_INIT = 2'b00
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int LO = WIDTH / 2;
  localparam int HI = WIDTH - LO;

  logic             cin0;
  logic [WIDTH-1:0] b_x;
  logic [LO:0]      lo_full;

  logic             s1_valid;
  logic [LO-1:0]    s1_lo_sum;
  logic             s1_c_mid;
  logic [HI-1:0]    s1_a_hi;
  logic [HI-1:0]    s1_b_hi;

  logic             s2_valid;

  logic [HI-1:0]    hi_low;
  logic             c_msb;
  logic             msb_sum;
  logic             cout_next;
  logic [HI-1:0]    hi_sum;

  logic             accept;
  logic             adv2;

  // Carry-init select; the unused 11 code behaves like 00.
  always_comb begin
    case (C_INIT)
      2'b01:   cin0 = 1'b1;
      2'b10:   cin0 = carry_in;
      default: cin0 = 1'b0;
    endcase
  end

  assign b_x     = b ^ {WIDTH{sub}};
  assign lo_full = {1'b0, a[LO-1:0]} + {1'b0, b_x[LO-1:0]} + {{LO{1'b0}}, cin0};

  // High half: ripple all but the MSB, then expose the carry into the MSB
  // explicitly so signed overflow can be formed from it.
  assign hi_low    = {1'b0, s1_a_hi[HI-2:0]} + {1'b0, s1_b_hi[HI-2:0]}
                   + {{(HI-1){1'b0}}, s1_c_mid};
  assign c_msb     = hi_low[HI-1];
  assign msb_sum   = s1_a_hi[HI-1] ^ s1_b_hi[HI-1] ^ c_msb;
  assign cout_next = (s1_a_hi[HI-1] & s1_b_hi[HI-1])
                   | (c_msb & (s1_a_hi[HI-1] ^ s1_b_hi[HI-1]));
  assign hi_sum    = {msb_sum, hi_low[HI-2:0]};

  // in_ready depends only on pipeline occupancy and out_ready, never on in_valid.
  assign in_ready  = !s1_valid || !s2_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign adv2      = s1_valid && (!s2_valid || out_ready);
  assign out_valid = s2_valid;

  // Stage 1: capture low-half sum, mid-carry and the pre-inverted high operands.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_valid  <= 1'b0;
      s1_lo_sum <= '0;
      s1_c_mid  <= 1'b0;
      s1_a_hi   <= '0;
      s1_b_hi   <= '0;
    end else begin
      if (clr) begin
        s1_valid <= 1'b0;
      end else if (accept) begin
        s1_valid <= 1'b1;
      end else if (adv2) begin
        s1_valid <= 1'b0;
      end
      if (accept) begin
        s1_lo_sum <= lo_full[LO-1:0];
        s1_c_mid  <= lo_full[LO];
        s1_a_hi   <= a[WIDTH-1:LO];
        s1_b_hi   <= b_x[WIDTH-1:LO];
      end
    end
  end

  // Stage 2: finish the high half and hold the result steady while stalled.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s2_valid <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      if (clr) begin
        s2_valid <= 1'b0;
      end else if (adv2) begin
        s2_valid <= 1'b1;
      end else if (out_ready) begin
        s2_valid <= 1'b0;
      end
      if (adv2) begin
        sum  <= {hi_sum, s1_lo_sum};
        cout <= cout_next;
        ovf  <= c_msb ^ cout_next;
      end
    end
  end

endmodule

// File: tb/tb_carry_chain_addsub_pipe.sv
// Bench for carry_chain_addsub_pipe: four instances, one per C_INIT code,
// share the same stimulus. A scoreboard queue holds the expected results of
// every accepted beat; the monitor pops and compares on each output transfer.
module tb_carry_chain_addsub_pipe;

  typedef struct packed {
    logic [3:0][15:0] s;
    logic [3:0]       c;
    logic [3:0]       o;
  } exp_t;

  logic        clk;
  logic        resetn;
  logic        clr;
  logic        in_valid;
  logic [15:0] a_i;
  logic [15:0] b_i;
  logic        sub_i;
  logic        ci_i;
  logic        out_ready;

  logic        in_ready_o  [4];
  logic        out_valid_o [4];
  logic [15:0] sum_o       [4];
  logic        cout_o      [4];
  logic        ovf_o       [4];

  int   n_vec;
  int   n_err;
  exp_t q[$];
  logic stim_done;
  logic prev_stall;
  logic [15:0] prev_sum;

  for (genvar k = 0; k < 4; k++) begin : g_dut
    carry_chain_addsub_pipe #(.WIDTH(16), .C_INIT(2'(k))) u_dut (
      .clk       (clk),
      .resetn    (resetn),
      .clr       (clr),
      .in_valid  (in_valid),
      .in_ready  (in_ready_o[k]),
      .a         (a_i),
      .b         (b_i),
      .sub       (sub_i),
      .carry_in  (ci_i),
      .out_valid (out_valid_o[k]),
      .out_ready (out_ready),
      .sum       (sum_o[k]),
      .cout      (cout_o[k]),
      .ovf       (ovf_o[k])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Reference: plain integer arithmetic on the operands, per C_INIT code.
  function automatic exp_t model(input logic [15:0] av, input logic [15:0] bv,
                                 input logic sv, input logic cv);
    exp_t        e;
    logic [15:0] bx;
    logic [16:0] tot;
    int          cin;
    int          sr;
    bx = sv ? ~bv : bv;
    for (int k = 0; k < 4; k++) begin
      cin    = (k == 1) ? 1 : ((k == 2) ? int'(cv) : 0);
      tot    = {1'b0, av} + {1'b0, bx} + 17'(cin);
      e.s[k] = tot[15:0];
      e.c[k] = tot[16];
      sr     = int'($signed(av)) + int'($signed(bx)) + cin;
      e.o[k] = (sr > 32767) || (sr < -32768);
    end
    return e;
  endfunction

  // Monitor first (outputs leaving this cycle), then record this cycle's accept.
  always @(negedge clk) begin
    exp_t e;
    if (!resetn) begin
      q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && out_valid_o[0]) chk("stall_hold_sum", sum_o[0], prev_sum);
      if (out_valid_o[0] && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_output", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          for (int k = 0; k < 4; k++) begin
            chk($sformatf("valid_c%0d", k), out_valid_o[k], 1);
            chk($sformatf("sum_c%0d", k), sum_o[k], e.s[k]);
            chk($sformatf("cout_c%0d", k), cout_o[k], e.c[k]);
            chk($sformatf("ovf_c%0d", k), ovf_o[k], e.o[k]);
          end
        end
      end
      prev_stall = out_valid_o[0] && !out_ready;
      prev_sum   = sum_o[0];
      if (clr) q.delete();
      else if (in_valid && in_ready_o[0]) q.push_back(model(a_i, b_i, sub_i, ci_i));
    end
  end

  // Hold one beat on the inputs until it is accepted; returns just after the accept edge.
  task automatic send(input logic [15:0] av, input logic [15:0] bv, input logic sv, input logic cv);
    logic got;
    int   budget;
    in_valid = 1'b1; a_i = av; b_i = bv; sub_i = sv; ci_i = cv;
    budget = 0;
    got = 1'b0;
    while (!got && budget < 50) begin
      @(negedge clk);
      got = in_ready_o[0];
      @(posedge clk); #1;
      budget++;
    end
    if (!got) chk("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic op_check(input logic [15:0] av, input logic [15:0] bv, input logic sv,
                          input logic cv, input int k, input logic [15:0] es,
                          input logic ec, input logic eo);
    send(av, bv, sv, cv);
    @(negedge clk);
    chk("latency_not_early", out_valid_o[k], 0);
    @(negedge clk);
    chk("latency_valid", out_valid_o[k], 1);
    chk("dir_sum", sum_o[k], es);
    chk("dir_cout", cout_o[k], ec);
    chk("dir_ovf", ovf_o[k], eo);
    @(posedge clk); #1;
  endtask

  initial begin
    logic rdy;
    int   nacc;
    int   budget;
    n_vec = 0; n_err = 0;
    stim_done = 1'b0;
    prev_stall = 1'b0; prev_sum = '0;
    resetn = 1'b0; clr = 1'b0; in_valid = 1'b0;
    a_i = '0; b_i = '0; sub_i = 1'b0; ci_i = 1'b0; out_ready = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready_o[0], 1);
    chk("rst_out_valid", out_valid_o[0], 0);
    chk("rst_sum", sum_o[0], 0);
    chk("rst_cout", cout_o[0], 0);
    chk("rst_ovf", ovf_o[0], 0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;

    // Directed arithmetic vectors
    op_check(16'h1234, 16'h0FFF, 1'b0, 1'b0, 0, 16'h2233, 1'b0, 1'b0);
    op_check(16'h00FF, 16'h0001, 1'b0, 1'b0, 0, 16'h0100, 1'b0, 1'b0);
    op_check(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 16'h0000, 1'b1, 1'b0);
    op_check(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, 16'h8000, 1'b0, 1'b1);
    op_check(16'h0005, 16'h0007, 1'b1, 1'b0, 1, 16'hFFFE, 1'b0, 1'b0);
    op_check(16'h0007, 16'h0005, 1'b1, 1'b0, 1, 16'h0002, 1'b1, 1'b0);
    op_check(16'h0000, 16'h0000, 1'b0, 1'b1, 2, 16'h0001, 1'b0, 1'b0);
    op_check(16'h0000, 16'h0000, 1'b0, 1'b1, 3, 16'h0000, 1'b0, 1'b0);
    op_check(16'h0000, 16'h0000, 1'b0, 1'b1, 0, 16'h0000, 1'b0, 1'b0);

    // Backpressure: two beats buffer, then in_ready drops and the output holds
    out_ready = 1'b0;
    in_valid = 1'b1; a_i = 16'd1; b_i = '0; sub_i = 1'b0; ci_i = 1'b0;
    nacc = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      rdy = in_ready_o[0];
      if (c >= 2) begin
        chk("bp_in_ready_low", rdy, 0);
        chk("bp_hold_valid", out_valid_o[0], 1);
        chk("bp_hold_sum", sum_o[0], 16'h0001);
      end
      @(posedge clk); #1;
      if (rdy) begin nacc++; a_i = a_i + 16'd1; end
    end
    chk("bp_accepts", nacc, 2);
    out_ready = 1'b1;
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      rdy = in_ready_o[0];
      chk("release_valid", out_valid_o[0], 1);
      chk("release_sum", sum_o[0], j);
      @(posedge clk); #1;
      if (rdy && in_valid) begin
        if (a_i == 16'd4) in_valid = 1'b0;
        else a_i = a_i + 16'd1;
      end
    end

    // Flush with two beats in flight and a simultaneous accept
    repeat (2) @(posedge clk); #1;
    out_ready = 1'b0;
    send(16'h0010, 16'h0000, 1'b0, 1'b0);
    send(16'h0020, 16'h0000, 1'b0, 1'b0);
    in_valid = 1'b1; a_i = 16'h0055; clr = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("clr_in_ready", in_ready_o[0], 1);
    for (int j = 0; j < 6; j++) begin
      chk("clr_no_stale", out_valid_o[0], 0);
      @(negedge clk);
    end
    @(posedge clk); #1;

    // Asynchronous reset in the middle of a stream
    in_valid = 1'b1;
    repeat (3) begin
      a_i = 16'($urandom); b_i = 16'($urandom);
      @(posedge clk); #1;
    end
    #2 resetn = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("arst_in_ready", in_ready_o[k], 1);
      chk("arst_out_valid", out_valid_o[k], 0);
      chk("arst_sum", sum_o[k], 0);
      chk("arst_cout", cout_o[k], 0);
      chk("arst_ovf", ovf_o[k], 0);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;

    // Randomized traffic with random backpressure and idle gaps
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        end
        stim_done = 1'b1;
      end
      begin
        while (!stim_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    budget = 0;
    while (q.size() > 0 && budget < 20) begin
      @(posedge clk); #1;
      budget++;
    end
    chk("drain_empty", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/carry_chain_addsub_pipe.md
# carry_chain_addsub_pipe

Two-stage pipelined adder/subtractor built on the carry chain, sitting directly downstream of the carry-init select logic. It computes `a + (b ^ {WIDTH{sub}}) + cin0`. The initial carry `cin0` is chosen by the same 2-bit `C_INIT` encoding the chain's carry-in mux uses. The chain is split at `WIDTH/2` with a registered mid-carry, so each stage drives only half a chain. Valid/ready streaming, throughput one beat per cycle.

## Interface
- `WIDTH`, 16: operand/result width; even, ≥ 4. `LO = WIDTH/2`.
- `C_INIT`, 2'b00: carry-init select. 00 → 0; 01 → 1; 10 → `carry_in` port; 11 → 0.
- `clk` in 1: sole clock, rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `clr` in 1: synchronous flush of all in-flight beats.
- `in_valid` in 1: input beat valid.
- `in_ready` out 1: input beat accepted when `in_valid && in_ready`.
- `a` in WIDTH: operand A.
- `b` in WIDTH: operand B.
- `sub` in 1: invert B bits.
- `carry_in` in 1: external carry; used only when `C_INIT == 2'b10`.
- `out_valid` out 1: result valid.
- `out_ready` in 1: downstream accepts the result.
- `sum` out WIDTH: result.
- `cout` out 1: carry out of bit WIDTH-1.
- `ovf` out 1: signed overflow (carry into MSB XOR `cout`).

## Operation
- **Input sampling.** `sub`, `carry_in`, `a` and `b` are sampled only on an accepted beat. `b' = b ^ {WIDTH{sub}}`.
- **No implied carry for subtraction.** `sub` does not force any carry. True two's-complement A−B requires `C_INIT = 01`, or `C_INIT = 10` with `carry_in = 1`.
- **Stage 1 on accept.**
  - Register `lo_sum = a[LO-1:0] + b'[LO-1:0] + cin0` (LO bits).
  - Register `c_mid`.
  - Register `a[WIDTH-1:LO]` and `b'[WIDTH-1:LO]`.
  - Set `s1_valid`.
- **Stage 2 on advance.**
  - `{cout, hi_sum} = a_hi + b'_hi + c_mid`.
  - `sum = {hi_sum, lo_sum}`.
  - `ovf = c_msb ^ cout`, where `c_msb` is the carry into bit WIDTH-1.
  - Set `s2_valid`. `out_valid = s2_valid`.
- **Advance rules.**
  - Stage 2 loads when `s1_valid && (!s2_valid || out_ready)`.
  - Stage 1 loads when `in_valid && in_ready`.
  - `in_ready = !s1_valid || !s2_valid || out_ready`. This is combinational from `out_ready` only; there is no path from `in_valid` to `in_ready`.
  - `s2_valid` clears on `out_ready` when nothing advances into stage 2.
- **Stall.** While `out_valid && !out_ready`, `sum`, `cout` and `ovf` hold stable. Stage 1 holds if occupied.
- **Overflow.** Arithmetic is modulo 2^WIDTH. Overflow is reported only via `cout` and `ovf`; no saturation.
- **`clr`.** Clears `s1_valid` and `s2_valid` next edge. Data registers are don't-care. `clr` takes priority over a simultaneous accept; that beat is dropped. `in_ready` is 1 the cycle after `clr`.
- **Unused select.** `C_INIT = 11` yields `cin0 = 0` regardless of `carry_in`.

## Timing
- **Reset.** `in_ready` = 1, `out_valid` = 0, `sum` = 0, `cout` = 0, `ovf` = 0, all internal valids 0.
- **Latency.** Accept at edge N → `out_valid` high after edge N+1 (two registered stages), when unstalled.
- **Throughput.** 1 beat/cycle with `out_ready` held high. Up to 2 beats are buffered under backpressure.
- **Ordering.** Results emerge in acceptance order; no beat is lost or duplicated.
- **Reset mid-operation.** Asynchronous assertion immediately forces the reset values above. In-flight beats are discarded. Deassertion is synchronised externally.
- **Critical path.** The longest carry path per stage is LO (or WIDTH−LO) bits plus one carry-init mux.

## Test plan
All scenarios use `WIDTH` = 16 (`LO` = 8) and `out_ready` = 1 unless stated.
- **Basic add.** `C_INIT`=00, a=0x1234, b=0x0FFF, sub=0 → `sum`=0x2233, `cout`=0, `ovf`=0, `out_valid` 2 cycles after accept.
- **Mid-split carry.** a=0x00FF, b=0x0001 → `sum`=0x0100. Then a=0xFFFF, b=0x0001 → `sum`=0x0000, `cout`=1, `ovf`=0. Then a=0x7FFF, b=0x0001 → `sum`=0x8000, `cout`=0, `ovf`=1.
- **Subtract.** `C_INIT`=01, sub=1, a=0x0005, b=0x0007 → `sum`=0xFFFE, `cout`=0. a=0x0007, b=0x0005 → `sum`=0x0002, `cout`=1.
- **Carry select.** `C_INIT`=10, `carry_in`=1, a=b=0 → `sum`=0x0001. `C_INIT`=11, `carry_in`=1 → `sum`=0x0000. `C_INIT`=00, `carry_in`=1 → `sum`=0x0000.
- **Backpressure.** Stream a=1,2,3,4 (b=0, `C_INIT`=00) with `out_ready`=0 for 4 cycles.
  - `in_ready` falls after 2 accepts.
  - `sum` holds at 0x0001 while stalled.
  - On release, outputs 1,2,3,4 appear in consecutive cycles.
- **Flush and reset.**
  - `clr` with 2 beats in flight plus an accept in the same cycle → `out_valid`=0 next cycle and no stale result ever appears.
  - `resetn` low mid-stream → outputs at reset values immediately, `in_ready`=1.
